// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the I-cache read port and dual-issue decode.
// Circular buffer exposing the two oldest entries; flush has highest priority.
module inst_fetch_queue #(
    parameter int DEPTH    = 16,
    parameter int AF_SLACK = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_inst,
    input  logic                     push_excp,
    input  logic [1:0]               pop_cnt,
    output logic                     out0_valid,
    output logic [31:0]              out0_pc,
    output logic [31:0]              out0_inst,
    output logic                     out0_excp,
    output logic                     out1_valid,
    output logic [31:0]              out1_pc,
    output logic [31:0]              out1_inst,
    output logic                     out1_excp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic          excp_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr1;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic [1:0]    pop_req;
    logic [1:0]    eff_pop;
    logic          eff_push;
    logic [CW-1:0] free_cnt;

    // Pointer width equals log2(DEPTH), so plain addition wraps modulo DEPTH.
    assign rd_ptr1 = rd_ptr + AW'(1);

    always_comb begin
        pop_req = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
        eff_pop = pop_req;
        if (count_q < CW'(pop_req)) begin
            eff_pop = count_q[1:0];
        end
    end

    assign full     = (count_q == CW'(DEPTH));
    assign eff_push = push_valid & ~full;
    assign free_cnt = CW'(DEPTH) - count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr + AW'(eff_pop);
            wr_ptr  <= wr_ptr + AW'(eff_push);
            count_q <= count_q + CW'(eff_push) - CW'(eff_pop);
            if (push_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset; validity comes solely from count.
    always_ff @(posedge clk) begin
        if (eff_push && !flush) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
            excp_mem[wr_ptr] <= push_excp;
        end
    end

    always_comb begin
        out0_valid = (count_q >= CW'(1));
        out1_valid = (count_q >= CW'(2));
        out0_pc    = '0;
        out0_inst  = '0;
        out0_excp  = 1'b0;
        out1_pc    = '0;
        out1_inst  = '0;
        out1_excp  = 1'b0;
        if (out0_valid) begin
            out0_pc   = pc_mem[rd_ptr];
            out0_inst = inst_mem[rd_ptr];
            out0_excp = excp_mem[rd_ptr];
        end
        if (out1_valid) begin
            out1_pc   = pc_mem[rd_ptr1];
            out1_inst = inst_mem[rd_ptr1];
            out1_excp = excp_mem[rd_ptr1];
        end
    end

    assign count       = count_q;
    assign almost_full = (32'(free_cnt) <= 32'(AF_SLACK));
    assign overflow    = overflow_q;

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction buffer directly downstream of the instruction cache's CPU read port.
- Captures each returned instruction word with its PC and fetch-exception flag, and presents up to two oldest entries to the dual-issue decode stage.
- Raises almost_full early enough to cover instructions already in flight through the two-stage cache pipeline.
- Flush drops all contents on branch mispredict or exception redirect.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- AF_SLACK, 3, almost_full asserts when free entries <= AF_SLACK.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all entries this cycle.
- push_valid  in  1  cache stage delivers one instruction this cycle.
- push_pc  in  32  PC of pushed instruction.
- push_inst  in  32  instruction word (cache read data).
- push_excp  in  1  fetch exception (e.g. misaligned PC) for the pushed entry.
- pop_cnt  in  2  entries consumed by decode this cycle: 0, 1 or 2; 3 is treated as 2.
- out0_valid  out  1  head entry present.
- out0_pc  out  32  head entry PC.
- out0_inst  out  32  head entry instruction word.
- out0_excp  out  1  head entry exception flag.
- out1_valid  out  1  second-oldest entry present.
- out1_pc  out  32  second-oldest entry PC.
- out1_inst  out  32  second-oldest entry instruction word.
- out1_excp  out  1  second-oldest entry exception flag.
- count  out  log2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- almost_full  out  1  (DEPTH - count) <= AF_SLACK.
- overflow  out  1  sticky: a push arrived while full.

Behaviour:
- Storage: circular buffer.
  - Pointers wr_ptr and rd_ptr, each log2(DEPTH) bits, wrap modulo DEPTH.
  - count register of log2(DEPTH)+1 bits.
- Reset (async assert): wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: out0_valid=out1_valid=0, full=0, almost_full=0.
  - Entry RAM contents are don't-care.
- Output timing: all outputs are combinational from registered state only; no input-to-output path.
  - out0 is the entry at rd_ptr; out1 is the entry at rd_ptr+1 (wrapped).
  - out0_valid = (count >= 1); out1_valid = (count >= 2).
  - When an outN_valid is 0, its pc/inst/excp drive 0.
- Push-to-visibility latency: an entry pushed at edge N is visible on out0/out1 after edge N. There is no same-cycle bypass.
- Pop legalisation: eff_pop = min(pop_cnt clamped to 2, count). Over-pop is silently clamped.
- Push acceptance: eff_push = push_valid & ~full, using full from the current cycle.
  - A push while full is dropped and sets overflow=1.
  - A push into a full queue is not accepted even if a pop occurs in the same cycle.
- Normal cycle updates:
  - rd_ptr += eff_pop.
  - wr_ptr += eff_push; the entry is written at the old wr_ptr.
  - count += eff_push - eff_pop.
- Flush (highest priority): on an edge with flush=1:
  - wr_ptr=rd_ptr=0, count=0; overflow cleared.
  - Any same-cycle push and pop are ignored.
  - Outputs are invalid the next cycle.
- Overflow is sticky until flush or reset. It indicates the almost_full stall contract was violated and is for assertion/debug only.
- Stall contract: the fetch unit stalls the PC when almost_full=1. With AF_SLACK=3, up to 3 in-flight cache responses must still fit, so overflow never sets in legal operation.
- Wrap-around: pointer increments across DEPTH-1 -> 0 must preserve order. out1 wraps independently of out0.
- Reset mid-operation: async assert clears state immediately regardless of clk. Deassertion is synchronous to the system reset synchroniser (external).

Test Plan:
- Reset then idle -> count=0, out0_valid=out1_valid=0, full=0, almost_full=0, all out data 0.
- Push pc 0xBFC00000..0xBFC0000C (insts 0x11,0x22,0x33,0x44), pop_cnt=0 -> count=4; out0_pc=0xBFC00000/inst 0x11; out1_pc=0xBFC00004/inst 0x22.
- From the 4-entry state, pop_cnt=2 with a simultaneous push of 0x55 -> count=3; out0_inst=0x33, out1_inst=0x44; 0x55 becomes third.
- Fill 16 entries -> almost_full first asserts at count=13 and full at 16.
  - 17th push -> dropped, overflow=1, count stays 16.
  - pop_cnt=3 -> treated as 2, count=14.
- Wrap test: 40 pushes interleaved with pops of 1/2 across the pointer wrap -> PC order out strictly sequential, no duplicate or lost entry.
- count=1, pop_cnt=2 -> count=0 (clamp). count=5 with flush, push and pop_cnt=2 all in one cycle -> count=0 and outputs invalid next cycle. rst pulsed between edges -> immediate clear.
